// File: rtl/chroma_recon8x8_pkg.sv
// rtl/chroma_recon8x8_pkg.sv - shared chroma intra constants and types
package chroma_recon8x8_pkg;

  // Mode encodings shared with the encoder-side mode decision.
  localparam logic [2:0] MODE_V  = 3'd0;
  localparam logic [2:0] MODE_H  = 3'd1;
  localparam logic [2:0] MODE_DC = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREP  = 2'd1,
    ROWS  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Largest unsigned pixel value for a given bit depth.
  function automatic int pix_max(input int bitdepth);
    return (1 << bitdepth) - 1;
  endfunction

endpackage

// File: rtl/chroma_recon8x8_recon_clip_row.sv
// rtl/chroma_recon8x8_recon_clip_row.sv - one row of prediction + residual with pixel clipping
module recon_clip_row
  import chroma_recon8x8_pkg::*;
#(
  parameter int BITDEPTH = 8,
  parameter int N        = 8
) (
  input  logic [N*BITDEPTH-1:0] pred_row,
  input  logic [N*BITDEPTH-1:0] res_row,
  output logic [N*BITDEPTH-1:0] pix_row
);

  // Two extra bits hold an unsigned pixel plus a signed residual without wrap.
  localparam int SW = BITDEPTH + 2;
  localparam logic signed [SW-1:0] MAXV = SW'(pix_max(BITDEPTH));

  for (genvar c = 0; c < N; c++) begin : g_col
    logic [BITDEPTH-1:0]  pred;
    logic [BITDEPTH-1:0]  res;
    logic signed [SW-1:0] sum;

    assign pred = pred_row[c*BITDEPTH +: BITDEPTH];
    assign res  = res_row[c*BITDEPTH +: BITDEPTH];
    assign sum  = $signed({2'b00, pred}) + $signed({{2{res[BITDEPTH-1]}}, res});

    assign pix_row[c*BITDEPTH +: BITDEPTH] =
      (sum < 0)    ? '0 :
      (sum > MAXV) ? MAXV[BITDEPTH-1:0] :
                     sum[BITDEPTH-1:0];
  end

endmodule

// File: rtl/chroma_recon8x8.sv
// rtl/chroma_recon8x8.sv - chroma 8x8 intra reconstruction, one row per handshake
module chroma_recon8x8
  import chroma_recon8x8_pkg::*;
#(
  parameter int BITDEPTH = 8,
  parameter int N        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            mode,
  input  logic [N*BITDEPTH-1:0] top,
  input  logic [N*BITDEPTH-1:0] left,
  input  logic                  top_avail,
  input  logic                  left_avail,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [N*BITDEPTH-1:0] res_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*BITDEPTH-1:0] out_row,
  output logic                  out_last,
  output logic                  busy
);

  localparam int RW   = $clog2(N);
  localparam int SUMW = BITDEPTH + 4;

  state_t                state_q, state_d;
  logic [RW-1:0]         row_q;
  logic [2:0]            mode_q;
  logic [N*BITDEPTH-1:0] top_q, left_q;
  logic                  top_av_q, left_av_q;
  logic [BITDEPTH-1:0]   dc_q, dc_d;
  logic [SUMW-1:0]       sum_t, sum_l, tmp_both, tmp_t, tmp_l;
  logic [BITDEPTH-1:0]   left_sel;
  logic [N*BITDEPTH-1:0] pred_row, pix_row;
  logic                  row_load, last_row;

  assign busy     = (state_q != IDLE);
  assign last_row = (row_q == RW'(N - 1));
  assign row_load = (state_q == ROWS) && res_valid && res_ready;
  assign left_sel = left_q[int'(row_q)*BITDEPTH +: BITDEPTH];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and residual-side ready.
  always_comb begin
    state_d   = state_q;
    res_ready = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = PREP;
      PREP:  state_d = ROWS;
      ROWS: begin
        res_ready = !out_valid || out_ready;
        if (res_valid && res_ready && last_row) state_d = DRAIN;
      end
      DRAIN: if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DC value from the captured neighbours, selected by availability.
  always_comb begin
    sum_t = '0;
    sum_l = '0;
    for (int c = 0; c < N; c++) begin
      sum_t = sum_t + SUMW'(top_q[c*BITDEPTH +: BITDEPTH]);
      sum_l = sum_l + SUMW'(left_q[c*BITDEPTH +: BITDEPTH]);
    end
    tmp_both = sum_t + sum_l + SUMW'(8);
    tmp_t    = sum_t + SUMW'(4);
    tmp_l    = sum_l + SUMW'(4);
    dc_d     = '0;
    case ({top_av_q, left_av_q})
      2'b11:   dc_d = tmp_both[BITDEPTH+3:4];
      2'b10:   dc_d = tmp_t[BITDEPTH+2:3];
      2'b01:   dc_d = tmp_l[BITDEPTH+2:3];
      default: dc_d[BITDEPTH-1] = 1'b1;
    endcase
  end

  // Prediction row for the current row counter; unknown modes fall back to vertical.
  always_comb begin
    pred_row = top_q;
    for (int c = 0; c < N; c++) begin
      case (mode_q)
        MODE_V:  pred_row[c*BITDEPTH +: BITDEPTH] = top_q[c*BITDEPTH +: BITDEPTH];
        MODE_H:  pred_row[c*BITDEPTH +: BITDEPTH] = left_sel;
        MODE_DC: pred_row[c*BITDEPTH +: BITDEPTH] = dc_q;
        default: pred_row[c*BITDEPTH +: BITDEPTH] = top_q[c*BITDEPTH +: BITDEPTH];
      endcase
    end
  end

  recon_clip_row #(
    .BITDEPTH (BITDEPTH),
    .N        (N)
  ) u_clip (
    .pred_row (pred_row),
    .res_row  (res_row),
    .pix_row  (pix_row)
  );

  // Block capture, DC register and row counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q    <= '0;
      top_q     <= '0;
      left_q    <= '0;
      top_av_q  <= 1'b0;
      left_av_q <= 1'b0;
      dc_q      <= '0;
      row_q     <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        mode_q    <= mode;
        top_q     <= top;
        left_q    <= left;
        top_av_q  <= top_avail;
        left_av_q <= left_avail;
        row_q     <= '0;
      end
      if (state_q == PREP) dc_q <= dc_d;
      if (row_load) row_q <= row_q + RW'(1);
    end
  end

  // Single output register: loads on an accepted row, holds until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_row   <= '0;
    end else if (row_load) begin
      out_valid <= 1'b1;
      out_last  <= last_row;
      out_row   <= pix_row;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chroma_recon8x8.sv
// tb/tb_chroma_recon8x8.sv - directed self-checking bench for chroma_recon8x8
module tb_chroma_recon8x8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mode;
  logic [63:0] top, left;
  logic        top_avail, left_avail;
  logic        res_valid, res_ready;
  logic [63:0] res_row;
  logic        out_valid, out_ready;
  logic [63:0] out_row;
  logic        out_last, busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] tv [8];
  logic [7:0] lv [8];
  logic [7:0] rp [8][8];
  logic [7:0] ep [8][8];

  always #5 clk = ~clk;

  chroma_recon8x8 #(.BITDEPTH(8), .N(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .top        (top),
    .left       (left),
    .top_avail  (top_avail),
    .left_avail (left_avail),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_row    (res_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_last   (out_last),
    .busy       (busy)
  );

  function automatic logic [63:0] top_vec();
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = tv[c];
    return v;
  endfunction

  function automatic logic [63:0] left_vec();
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = lv[c];
    return v;
  endfunction

  function automatic logic [63:0] res_vec(input int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = rp[r][c];
    return v;
  endfunction

  function automatic logic [63:0] exp_vec(input int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[c*8 +: 8] = ep[r][c];
    return v;
  endfunction

  task automatic run_block(input string name, input logic [2:0] m, input logic ta, input logic la,
                           input int stall_at, input int stall_len, input int abort_at,
                           input bit extra_start);
    int sent, recv, stall_cnt, cyc;
    bit prev_acc, prev_valid, prev_ready, extra_done, stall, acc_res, acc_out, exp_valid;
    logic [63:0] prev_row;
    sent = 0; recv = 0; stall_cnt = 0; cyc = 0;
    prev_acc = 0; prev_valid = 0; prev_ready = 1; extra_done = 0;
    prev_row = '0;
    mode = m; top = top_vec(); left = left_vec();
    top_avail = ta; left_avail = la;
    res_valid = 0; out_ready = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    tests++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    if (busy !== 1'b1) fails++;
    while (recv < 8 && cyc < 200) begin
      stall = (recv == stall_at) && (stall_cnt < stall_len) && out_valid;
      if (stall) stall_cnt++;
      out_ready = !stall;
      res_valid = (sent < 8);
      res_row   = (sent < 8) ? res_vec(sent) : '0;
      start     = extra_start && !extra_done && (sent == 3);
      if (start) begin
        extra_done = 1;
        mode = 3'd2;
      end
      #1;
      acc_res   = res_valid && res_ready;
      acc_out   = out_valid && out_ready;
      exp_valid = prev_acc || (prev_valid && !prev_ready);
      tests++;
      if (out_valid !== exp_valid) begin
        fails++;
        $display("FAIL %s valid_timing cyc %0d: got %b expected %b", name, cyc, out_valid, exp_valid);
      end
      if (prev_valid && !prev_ready) begin
        tests++;
        if (out_row !== prev_row) begin
          fails++;
          $display("FAIL %s row_stable: got %h expected %h", name, out_row, prev_row);
        end
      end
      if (out_valid && !out_ready) begin
        tests++;
        if (res_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s res_ready_stall: got %b expected 0", name, res_ready);
        end
      end
      if (acc_out) begin
        tests++;
        if (out_row !== exp_vec(recv)) begin
          fails++;
          $display("FAIL %s row%0d: got %h expected %h", name, recv, out_row, exp_vec(recv));
        end
        tests++;
        if (out_last !== (recv == 7)) begin
          fails++;
          $display("FAIL %s last%0d: got %b expected %b", name, recv, out_last, (recv == 7));
        end
        recv++;
      end
      if (acc_res) sent++;
      prev_acc   = acc_res;
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_row   = out_row;
      start      = 0;
      @(posedge clk); #1;
      cyc++;
      if (abort_at >= 0 && sent == abort_at) begin
        reset = 0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s abort: got valid %b busy %b ready %b expected 0 0 0",
                   name, out_valid, busy, res_ready);
        end
        res_valid = 0;
        reset = 1;
        @(posedge clk); #1;
        return;
      end
    end
    res_valid = 0;
    out_ready = 1;
    tests++;
    if (recv != 8) begin
      fails++;
      $display("FAIL %s row_count: got %0d expected 8", name, recv);
    end
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s end_idle: got busy %b valid %b expected 0 0", name, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 0; start = 0; mode = 0; top = '0; left = '0;
    top_avail = 0; left_avail = 0; res_valid = 0; res_row = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        res_ready !== 1'b0 || out_row !== 64'h0) begin
      fails++;
      $display("FAIL reset_state: got valid %b last %b busy %b ready %b row %h expected all 0",
               out_valid, out_last, busy, res_ready, out_row);
    end
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic set_vertical_plus1();
    for (int c = 0; c < 8; c++) begin
      tv[c] = 8'(10 * (c + 1));
      lv[c] = 8'd0;
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rp[r][c] = 8'd1;
        ep[r][c] = 8'(11 + 10 * c);
      end
  endtask

  task automatic test_vertical();
    set_vertical_plus1();
    run_block("vertical", 3'd0, 1'b1, 1'b1, -1, 0, -1, 1'b0);
  endtask

  task automatic test_horizontal_clip();
    for (int c = 0; c < 8; c++) begin
      tv[c] = 8'd0;
      lv[c] = 8'd250;
    end
    lv[1] = 8'd100;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rp[r][c] = (r == 0) ? 8'd10 : (r == 1) ? 8'h80 : 8'd0;
        ep[r][c] = (r == 0) ? 8'd255 : (r == 1) ? 8'd0 : 8'd250;
      end
    run_block("horizontal_clip", 3'd1, 1'b0, 1'b0, -1, 0, -1, 1'b0);
  endtask

  task automatic set_dc(input logic [7:0] dcv);
    for (int c = 0; c < 8; c++) begin
      tv[c] = 8'd16;
      lv[c] = 8'd48;
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rp[r][c] = 8'd0;
        ep[r][c] = dcv;
      end
  endtask

  task automatic test_dc_back_to_back();
    set_dc(8'd32);
    run_block("dc_both", 3'd2, 1'b1, 1'b1, -1, 0, -1, 1'b0);
    set_dc(8'd48);
    run_block("dc_left", 3'd2, 1'b0, 1'b1, -1, 0, -1, 1'b0);
    set_dc(8'd16);
    run_block("dc_top", 3'd2, 1'b1, 1'b0, -1, 0, -1, 1'b0);
    set_dc(8'd128);
    run_block("dc_none", 3'd2, 1'b0, 1'b0, -1, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 8; c++) begin
      tv[c] = 8'(10 * (c + 1));
      lv[c] = 8'd0;
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        rp[r][c] = 8'(r);
        ep[r][c] = 8'(10 * (c + 1) + r);
      end
    run_block("backpressure", 3'd0, 1'b0, 1'b0, 3, 3, -1, 1'b0);
  endtask

  task automatic test_reset_mid_block();
    set_vertical_plus1();
    run_block("abort", 3'd0, 1'b1, 1'b1, -1, 0, 5, 1'b0);
    set_dc(8'd32);
    run_block("after_abort", 3'd2, 1'b1, 1'b1, -1, 0, -1, 1'b0);
  endtask

  task automatic test_start_busy_mode5();
    set_vertical_plus1();
    run_block("mode5_extra_start", 3'd5, 1'b0, 1'b0, -1, 0, -1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_vertical();
    test_horizontal_clip();
    test_dc_back_to_back();
    test_backpressure();
    test_reset_mid_block();
    test_start_busy_mode5();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chroma_recon8x8.md
Name: chroma_recon8x8

Overview:
- Decoder-side counterpart of the chroma 8x8 intra mode decision. Takes the chosen intra mode, the neighbouring reconstructed samples and the residual, rebuilds the prediction, adds the residual, and emits clipped reconstructed pixels row by row.
- Sits after the inverse transform / residual path, which supplies one residual row per handshake. Feeds the frame-buffer writer and the neighbour store.

Parameters:
- BITDEPTH, 8, pixel width. Residual width is also BITDEPTH, signed.
- N, 8, block dimension. Only 8 is supported; it fixes the row count and the DC shifts.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; captures mode, top, left, top_avail, left_avail. Honoured only in IDLE.
- mode  in  3  0 = vertical, 1 = horizontal, 2 = DC; 3..7 treated as vertical.
- top  in  N*BITDEPTH  unsigned samples above the block, index 0 = leftmost.
- left  in  N*BITDEPTH  unsigned samples left of the block, index 0 = topmost.
- top_avail  in  1  top neighbours valid (used for DC only).
- left_avail  in  1  left neighbours valid (used for DC only).
- res_valid  in  1  residual row present.
- res_ready  out  1  block accepts the residual row.
- res_row  in  N*BITDEPTH  signed residuals, one row, index 0 = column 0.
- out_valid  out  1  reconstructed row present.
- out_ready  in  1  downstream accepts the row.
- out_row  out  N*BITDEPTH  unsigned reconstructed pixels.
- out_last  out  1  high with row 7.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, active low): state IDLE; row counter 0; out_valid, out_last, busy, res_ready all 0; out_row 0; captured mode/neighbours/DC register 0.
- FSM IDLE -> PREP -> ROWS -> DRAIN -> IDLE.
- IDLE: on start, latch all block inputs and go to PREP.
- PREP (exactly 1 cycle): compute the DC register.
  - Both neighbour sets available: (sum top + sum left + 8) >> 4.
  - Only top available: (sum top + 4) >> 3.
  - Only left available: (sum left + 4) >> 3.
  - Neither available: 1 << (BITDEPTH-1) = 128.
  - Sums use BITDEPTH+4 bits with no overflow.
- ROWS:
  - res_ready = !out_valid || out_ready (single output register, full throughput).
  - On a res_valid && res_ready row r, column c:
    - pred = top[c] for vertical, left[r] for horizontal, the DC register for DC.
    - sum = pred + res, computed in BITDEPTH+2 bits signed.
    - Clip the sum to [0, 2^BITDEPTH - 1].
    - Register the row into out_row next cycle with out_valid = 1 (latency 1); out_last = (r == 7); increment r.
  - Accepting r = 7 moves to DRAIN.
- DRAIN: res_ready = 0. When out_valid && out_ready, go to IDLE.
- Output register rules (all states):
  - out_valid holds until accepted; out_row and out_last stay stable while out_valid && !out_ready.
  - out_valid clears on acceptance unless a new row loads in the same cycle.
- Neighbour samples drive vertical and horizontal prediction regardless of the avail flags. Guaranteeing their validity for those modes is the caller's responsibility.
- busy = (state != IDLE). start is ignored while busy.
- Asynchronous reset mid-block aborts immediately; no partial output follows.
- Back-to-back blocks: start is accepted in the cycle after the last out handshake. A start coinciding with the DRAIN acceptance cycle is ignored.

Decomposition:
- Shared package (chroma intra constants):
  - mode encodings MODE_V = 0, MODE_H = 1, MODE_DC = 2, common with the encoder-side decision.
  - state enum {IDLE, PREP, ROWS, DRAIN}.
  - Constant for the pixel maximum.
- One natural sub-module, recon_clip_row: purely combinational, N adders plus clips, pred row + residual row -> pixel row. The parent holds the FSM, counter, DC computation and output register.

Test Plan:
- Vertical: top = 10,20,...,80, all residuals +1, out_ready = 1 -> 8 rows each 11,21,...,81; out_last on the 8th out_valid only; outputs start 1 cycle after each accepted row.
- Horizontal with clip: left = 250 for all, residuals +10 on row 0 and -128 on row 1; left[1] = 100 -> row 0 all 255, row 1 all 0.
- DC availability: top = 16 each, left = 48 each, both avail -> DC 32; only left avail -> 48; neither -> 128. Zero residual gives rows equal to the DC value.
- Backpressure: out_ready held low 3 cycles after row 2 -> res_ready low, out_row stable, no row lost or duplicated; exactly 8 rows in order.
- Reset mid-block: assert reset after row 4 accepted -> out_valid 0 and busy 0 immediately; a new start then yields a fresh 8-row block.
- Start while busy, and mode 5: extra start during ROWS is ignored (exactly 8 rows); mode 5 reconstructs identically to vertical.
